// File: rtl/px_ctrl_pkg.sv
// Shared types and helpers for the PxSensor frame sequencer.
// Gray-coded conversion is enabled by defining PX_CTRL_GRAY_EN.
package px_ctrl_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TIME_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_TURN,
    ST_READOUT
  } px_state_e;

  // Per-row readout sub-phase: select, capture, then hold valid until accepted
  typedef enum logic [1:0] {
    RD_SEL,
    RD_CAP,
    RD_VALID
  } px_rd_phase_e;

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = int'(CNT_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/px_ramp_counter.sv
// Conversion step counter with two-phase RAMP strobe (strobe cycle, then count cycle).
// With PX_CTRL_GRAY_EN defined the driven count is Gray-coded.
module px_ramp_counter
  import px_ctrl_pkg::*;
#(
  parameter int unsigned CONV_STEPS = 256
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  output logic             ramp,
  output logic [CNT_W-1:0] cnt_data,
  output logic             done_c
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CONV_STEPS - 1);

  logic             active;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] step_inc;
  logic [CNT_W-1:0] step_enc_c;

  assign step_inc = step + CNT_W'(1);

`ifdef PX_CTRL_GRAY_EN
  assign step_enc_c = bin2gray(step_inc);
`else
  assign step_enc_c = step_inc;
`endif

  // Final count cycle of the last step; the FSM leaves CONVERT on this edge
  assign done_c = active && !ramp && (step == LAST_STEP);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      active   <= 1'b0;
      ramp     <= 1'b0;
      step     <= '0;
      cnt_data <= '0;
    end else if (start) begin
      active   <= 1'b1;
      ramp     <= 1'b1;
      step     <= '0;
      cnt_data <= '0;
    end else if (active) begin
      if (ramp) begin
        ramp <= 1'b0;
      end else if (step == LAST_STEP) begin
        active   <= 1'b0;
        step     <= '0;
        cnt_data <= '0;
      end else begin
        ramp     <= 1'b1;
        step     <= step_inc;
        cnt_data <= step_enc_c;
      end
    end
  end

endmodule

// File: rtl/px_sensor_ctrl.sv
// Frame sequencer for a PxSensor pixel column: erase, expose, ramp conversion, row readout.
// Define PX_CTRL_GRAY_EN for a Gray-coded ramp count and Gray-decoded pixel capture.
module px_sensor_ctrl
  import px_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS     = 2,
  parameter int unsigned ERASE_CYCLES = 4,
  parameter int unsigned CONV_STEPS   = 256,
  parameter int unsigned ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [TIME_W-1:0]   EXPOSE_TIME,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERASE,
  output logic                EXPOSE,
  output logic                RAMP,
  output logic                CNT_OE,
  output logic [CNT_W-1:0]    CNT_DATA,
  output logic [NUM_ROWS-1:0] READ,
  input  logic [CNT_W-1:0]    DATA_IN,
  output logic [CNT_W-1:0]    PIX_OUT,
  output logic [ROW_W-1:0]    PIX_ROW,
  output logic                PIX_VALID,
  input  logic                PIX_READY
);

  localparam logic [TIME_W-1:0] ERASE_LAST = TIME_W'(ERASE_CYCLES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_ROWS - 1);

  px_state_e           state_q, state_d;
  px_rd_phase_e        rd_ph_q, rd_ph_d;
  logic [TIME_W-1:0]   tmr_q, tmr_d;
  logic [TIME_W-1:0]   exp_time_q, exp_time_d;
  logic [ROW_W-1:0]    row_q, row_d;

  logic                ramp_start_c;
  logic                ramp_done_c;
  logic                capture_c;
  logic [CNT_W-1:0]    pix_dec_c;

  logic                busy_d, done_d, erase_d, expose_d, cnt_oe_d, valid_d;
  logic [NUM_ROWS-1:0] read_d;

`ifdef PX_CTRL_GRAY_EN
  assign pix_dec_c = gray2bin(DATA_IN);
`else
  assign pix_dec_c = DATA_IN;
`endif

  px_ramp_counter #(
    .CONV_STEPS (CONV_STEPS)
  ) u_ramp (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (ramp_start_c),
    .ramp     (RAMP),
    .cnt_data (CNT_DATA),
    .done_c   (ramp_done_c)
  );

  // Next-state logic; outputs are then decoded from the next state so they register in step
  always_comb begin
    state_d      = state_q;
    rd_ph_d      = rd_ph_q;
    tmr_d        = tmr_q;
    exp_time_d   = exp_time_q;
    row_d        = row_q;
    ramp_start_c = 1'b0;
    capture_c    = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_ERASE;
          tmr_d      = '0;
          exp_time_d = EXPOSE_TIME;
        end
      end
      ST_ERASE: begin
        if (tmr_q == ERASE_LAST) begin
          tmr_d = '0;
          if (exp_time_q == '0) begin
            state_d      = ST_CONVERT;
            ramp_start_c = 1'b1;
          end else begin
            state_d = ST_EXPOSE;
          end
        end else begin
          tmr_d = tmr_q + TIME_W'(1);
        end
      end
      ST_EXPOSE: begin
        if (tmr_q == exp_time_q - TIME_W'(1)) begin
          tmr_d        = '0;
          state_d      = ST_CONVERT;
          ramp_start_c = 1'b1;
        end else begin
          tmr_d = tmr_q + TIME_W'(1);
        end
      end
      ST_CONVERT: begin
        if (ramp_done_c) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        state_d = ST_READOUT;
        row_d   = '0;
        rd_ph_d = RD_SEL;
      end
      ST_READOUT: begin
        case (rd_ph_q)
          RD_SEL: rd_ph_d = RD_CAP;
          RD_CAP: begin
            rd_ph_d   = RD_VALID;
            capture_c = 1'b1;
          end
          RD_VALID: begin
            if (PIX_READY) begin
              rd_ph_d = RD_SEL;
              if (row_q == LAST_ROW) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end
          end
          default: rd_ph_d = RD_SEL;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d   = (state_d != ST_IDLE);
    erase_d  = (state_d == ST_ERASE);
    expose_d = (state_d == ST_EXPOSE);
    cnt_oe_d = (state_d == ST_CONVERT);
    valid_d  = (state_d == ST_READOUT) && (rd_ph_d == RD_VALID);
    read_d   = '0;
    if ((state_d == ST_READOUT) && (rd_ph_d != RD_VALID)) begin
      read_d = NUM_ROWS'(1) << row_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rd_ph_q    <= RD_SEL;
      tmr_q      <= '0;
      exp_time_q <= '0;
      row_q      <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      CNT_OE     <= 1'b0;
      READ       <= '0;
      PIX_OUT    <= '0;
      PIX_ROW    <= '0;
      PIX_VALID  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ph_q    <= rd_ph_d;
      tmr_q      <= tmr_d;
      exp_time_q <= exp_time_d;
      row_q      <= row_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      ERASE      <= erase_d;
      EXPOSE     <= expose_d;
      CNT_OE     <= cnt_oe_d;
      READ       <= read_d;
      PIX_VALID  <= valid_d;
      if (capture_c) begin
        PIX_OUT <= pix_dec_c;
        PIX_ROW <= row_q;
      end
    end
  end

endmodule

// File: tb/tb_px_sensor_ctrl.sv
// Self-checking bench for px_sensor_ctrl: frame timeline model plus randomized readout scoreboard.
// Honours PX_CTRL_GRAY_EN the same way as the design.
module tb_px_sensor_ctrl;

  localparam int NUM_ROWS     = 2;
  localparam int ERASE_CYCLES = 4;
  localparam int CONV_STEPS   = 256;

  logic                CLK = 1'b0;
  logic                RESET;
  logic                START;
  logic [15:0]         EXPOSE_TIME;
  logic                BUSY, DONE, ERASE, EXPOSE, RAMP, CNT_OE, PIX_VALID;
  logic [7:0]          CNT_DATA;
  logic [NUM_ROWS-1:0] READ;
  logic [7:0]          DATA_IN;
  logic [7:0]          PIX_OUT;
  logic [0:0]          PIX_ROW;
  logic                PIX_READY;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [7:0] pix_val [NUM_ROWS];

  always #5 CLK = ~CLK;

  px_sensor_ctrl #(
    .NUM_ROWS     (NUM_ROWS),
    .ERASE_CYCLES (ERASE_CYCLES),
    .CONV_STEPS   (CONV_STEPS)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .EXPOSE_TIME (EXPOSE_TIME),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERASE       (ERASE),
    .EXPOSE      (EXPOSE),
    .RAMP        (RAMP),
    .CNT_OE      (CNT_OE),
    .CNT_DATA    (CNT_DATA),
    .READ        (READ),
    .DATA_IN     (DATA_IN),
    .PIX_OUT     (PIX_OUT),
    .PIX_ROW     (PIX_ROW),
    .PIX_VALID   (PIX_VALID),
    .PIX_READY   (PIX_READY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gray(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  // Ramp count as it should appear on the bus, and pixel value as the pixel drives it
  function automatic logic [7:0] cnt_enc(input logic [7:0] k);
`ifdef PX_CTRL_GRAY_EN
    return gray(k);
`else
    return k;
`endif
  endfunction

  function automatic logic [7:0] bus_val(input logic [7:0] v);
`ifdef PX_CTRL_GRAY_EN
    return gray(v);
`else
    return v;
`endif
  endfunction

  // {BUSY, DONE, ERASE, EXPOSE, RAMP, CNT_OE, CNT_DATA, READ, PIX_VALID}
  function automatic logic [31:0] outs();
    return 32'({BUSY, DONE, ERASE, EXPOSE, RAMP, CNT_OE, CNT_DATA, READ, PIX_VALID});
  endfunction

  // Pixel array model: the selected pixel drives the shared bus, otherwise junk
  task automatic drive_bus();
    if (READ[0])      DATA_IN = bus_val(pix_val[0]);
    else if (READ[1]) DATA_IN = bus_val(pix_val[1]);
    else              DATA_IN = 8'($urandom);
  endtask

  always @(negedge CLK) begin
    if (mon_en) check("bus_excl", 32'(!(CNT_OE && (|READ)) && $onehot0(READ)), 32'd1);
  end

  task automatic run_frame(input int e, input int mid_start, input int rst_at,
                           input int stall, input bit rnd_ready);
    int         base, fixed_len, r, k, stall_cnt;
    bit         erase_x, expose_x, conv_x, ramp_x, exp_v, rdy, last_acc;
    logic [7:0] cd;
    logic [1:0] exp_rd;
    base      = ERASE_CYCLES + e;
    fixed_len = base + 2 * CONV_STEPS + 1;
    PIX_READY = 1'b0;
    START       = 1'b1;
    EXPOSE_TIME = 16'(e);
    @(negedge CLK);
    START       = 1'b0;
    EXPOSE_TIME = 16'($urandom);
    for (int c = 0; c < fixed_len; c++) begin
      erase_x  = (c < ERASE_CYCLES);
      expose_x = (c >= ERASE_CYCLES) && (c < base);
      conv_x   = (c >= base) && (c < base + 2 * CONV_STEPS);
      ramp_x   = conv_x && (((c - base) % 2) == 0);
      cd       = conv_x ? cnt_enc(8'((c - base) / 2)) : 8'h00;
      check($sformatf("seq_e%0d_c%0d", e, c), outs(),
            32'({1'b1, 1'b0, erase_x, expose_x, ramp_x, conv_x, cd, 2'b00, 1'b0}));
      drive_bus();
      START = (c == mid_start);
      if (c == rst_at) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        check("rst_outs", outs(), 32'd0);
        check("rst_pix", 32'({PIX_OUT, PIX_ROW}), 32'd0);
        repeat (3) begin
          @(negedge CLK);
          check("rst_idle", outs(), 32'd0);
        end
        return;
      end
      @(negedge CLK);
    end
    START     = 1'b0;
    r         = 0;
    k         = 0;
    stall_cnt = 0;
    last_acc  = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      exp_v  = (k >= 2);
      exp_rd = (k < 2) ? 2'(1 << r) : 2'b00;
      check($sformatf("rd_r%0d_k%0d", r, k), outs(),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, exp_rd, exp_v}));
      if (exp_v) begin
        check($sformatf("pix_out_r%0d", r), 32'(PIX_OUT), 32'(pix_val[r]));
        check($sformatf("pix_row_r%0d", r), 32'(PIX_ROW), 32'(r));
      end
      drive_bus();
      if (exp_v && r == 0 && stall_cnt < stall) begin
        rdy = 1'b0;
        stall_cnt++;
      end else begin
        rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      PIX_READY = rdy;
      if (exp_v && rdy) begin
        if (r == NUM_ROWS - 1) last_acc = 1'b1;
        r++;
        k = 0;
      end else if (k < 2) begin
        k++;
      end
      @(negedge CLK);
      if (last_acc) break;
    end
    if (!last_acc) begin
      check("rd_timeout", 32'd1, 32'd0);
      return;
    end
    PIX_READY = 1'b0;
    check("done_pulse", outs(), 32'({1'b0, 1'b1, 15'd0}));
    @(negedge CLK);
    check("post_idle", outs(), 32'd0);
  endtask

  initial begin
    RESET       = 1'b1;
    START       = 1'b0;
    EXPOSE_TIME = 16'd0;
    DATA_IN     = 8'h00;
    PIX_READY   = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outs", outs(), 32'd0);
    check("reset_pix", 32'({PIX_OUT, PIX_ROW}), 32'd0);
    RESET  = 1'b0;
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("idle", outs(), 32'd0);
    end

    pix_val[0] = 8'h5A;
    pix_val[1] = 8'hC3;
    run_frame(10, -1, -1, 0, 1'b0);

    pix_val[0] = 8'($urandom);
    pix_val[1] = 8'($urandom);
    run_frame(3, -1, -1, 20, 1'b0);

    pix_val[0] = 8'($urandom);
    pix_val[1] = 8'($urandom);
    run_frame(0, 100, -1, 0, 1'b1);

    run_frame(7, -1, ERASE_CYCLES + 7 + 200, 0, 1'b0);
    pix_val[0] = 8'd77;
    pix_val[1] = 8'($urandom);
    run_frame(5, -1, -1, 0, 1'b1);

    repeat (3) begin
      pix_val[0] = 8'($urandom);
      pix_val[1] = 8'($urandom);
      run_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 600)), -1,
                int'($urandom_range(0, 5)), 1'b1);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/px_sensor_ctrl.md
Name: px_sensor_ctrl

Overview:
Frame sequencer for a column of PxSensor pixels sharing one 8-bit DATA bus. Per START it drives ERASE, then EXPOSE for a programmed time, then a RAMP/counter conversion phase, then row-by-row readout. Readout uses a valid/ready stream to the downstream frame buffer. Sits between the top-level camera control and the analog pixel array.

Parameters:
NUM_ROWS, 2, pixels sharing the DATA bus; one READ line each.
ERASE_CYCLES, 4, cycles ERASE held high.
CONV_STEPS, 256, ramp steps per conversion, at most 256.
ROW_W, $clog2(NUM_ROWS) (min 1), row index width.

Ports:
CLK  input  1  system clock.
RESET  input  1  synchronous, active-high reset.
START  input  1  one-cycle frame request; sampled only in IDLE.
EXPOSE_TIME  input  16  exposure length in cycles; latched on accepted START.
BUSY  output  1  high in every state except IDLE.
DONE  output  1  one-cycle pulse after the last row is accepted.
ERASE  output  1  pixel erase.
EXPOSE  output  1  pixel expose enable.
RAMP  output  1  comparator ramp strobe.
CNT_OE  output  1  controller drives CNT_DATA onto the shared bus.
CNT_DATA  output  8  ramp counter value.
READ  output  NUM_ROWS  one-hot pixel read enable.
DATA_IN  input  8  shared bus sampled during readout.
PIX_OUT  output  8  captured pixel value.
PIX_ROW  output  ROW_W  row index of PIX_OUT.
PIX_VALID  output  1  PIX_OUT valid.
PIX_READY  input  1  downstream accepts.

Behaviour:
- All outputs are registered. The reset value of every output is 0; the state after reset is IDLE.
- States and transitions:
  - IDLE -> ERASE on START.
  - ERASE: ERASE=1 for ERASE_CYCLES cycles, then EXPOSE.
  - EXPOSE: EXPOSE=1 for exactly the latched EXPOSE_TIME cycles, then CONVERT. If EXPOSE_TIME=0, EXPOSE stays 0 and the FSM goes straight to CONVERT after ERASE.
  - CONVERT: two cycles per step. CNT_OE=1 throughout. Cycle A: RAMP=1. Cycle B: RAMP=0, then CNT_DATA increments. After CONV_STEPS steps, go to TURN.
  - TURN: one cycle with CNT_OE=0 and READ=0 for bus turnaround, then READOUT at row 0.
- Readout sequence, per row r:
  - Cycle 1: READ[r]=1.
  - Cycle 2: READ[r] stays 1; DATA_IN is captured into PIX_OUT; PIX_ROW=r.
  - Then READ=0, PIX_VALID=1. PIX_OUT and PIX_ROW are held stable until PIX_READY.
  - On the valid&&ready cycle, PIX_VALID drops the next cycle and row r+1 begins.
  - After row NUM_ROWS-1 is accepted, DONE pulses and the FSM returns to IDLE.
- Bus exclusivity: CNT_OE and any READ bit are never high in the same cycle. At most one READ bit is high at any time.
- CNT_DATA is 8-bit and starts at 0 each CONVERT. Its value in step k is k. CONV_STEPS=256 ends at 255 with no wrap driven; the counter is cleared to 0 on entering TURN.
- START outside IDLE is ignored. EXPOSE_TIME changes after latch have no effect.
- RESET asserted in any state returns IDLE on the next edge and clears all outputs, including a pending PIX_VALID. The frame is lost and DONE does not pulse.
- PIX_READY held high means one row every 3 cycles. PIX_READY held low stalls indefinitely in READOUT with BUSY=1.

Optional Feature:
PX_CTRL_GRAY_EN
- Defined: CNT_DATA is the Gray encoding of step k, so exactly one bit changes per step. PIX_OUT is Gray-decoded to binary before output.
- Undefined: plain binary counter and pass-through capture.
- Cycle timing is identical in both builds.

Decomposition:
- Package px_ctrl_pkg holds:
  - the state enum (IDLE, ERASE, EXPOSE, CONVERT, TURN, READOUT);
  - the constant CNT_W=8;
  - the bin2gray and gray2bin functions.
- Sub-module px_ramp_counter: step counter with the two-phase RAMP generator, start/done handshake to the FSM, and optional Gray encoding.

Test Plan:
- RESET, then START with EXPOSE_TIME=10 -> ERASE high 4 cycles, EXPOSE high 10 cycles, 256 RAMP pulses, CNT_DATA 0..255, one idle TURN cycle, 2 rows read, DONE pulse, BUSY low.
- DATA_IN=8'h5A for row 0 and 8'hC3 for row 1, PIX_READY=1 -> PIX_OUT 5A with PIX_ROW=0, then C3 with PIX_ROW=1; each PIX_VALID lasts one cycle.
- PIX_READY low 20 cycles on row 0 -> PIX_VALID, PIX_OUT and PIX_ROW held stable; READ[1] stays low; row 1 begins after ready.
- EXPOSE_TIME=0 -> EXPOSE never asserted; CONVERT starts the cycle after ERASE ends. A second START mid-frame -> ignored.
- RESET at CONVERT step 100 -> next cycle all outputs 0, state IDLE, no DONE. A fresh START then runs a full frame.
- Build with PX_CTRL_GRAY_EN -> CNT_DATA changes one bit per step. DATA_IN=gray(77) -> PIX_OUT=77.
- Assertion throughout every test: never CNT_OE && |READ; $onehot0(READ).
